// File: rtl/riscv_pert_dbg_master.sv
// Debug-bus initiator: queues commands in a small FIFO and runs each one as a single
// req/gnt/rvalid transaction, returning exactly one response per command, in order.
module riscv_pert_dbg_master #(
  parameter int unsigned CMD_DEPTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [14:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_error_o,
  output logic        busy_o,
  output logic        dbg_req_o,
  input  logic        dbg_gnt_i,
  input  logic        dbg_rvalid_i,
  output logic        dbg_we_o,
  output logic [14:0] dbg_addr_o,
  output logic [31:0] dbg_wdata_o,
  input  logic [31:0] dbg_rdata_i
);

  localparam int unsigned PtrW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned TmrW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT_CYCLES - 1);
  localparam bit TmoEn = (TIMEOUT_CYCLES != 0);

  typedef struct packed {
    logic        we;
    logic [14:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {StIdle, StReq, StWaitRv, StResp} state_e;

  cmd_t              fifo_q [CMD_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ready_q;
  state_e            state_q;
  logic [TmrW-1:0]   tmr_q;
  logic              req_q, we_q, we_pend_q;
  logic [14:0]       addr_q;
  logic [31:0]       wdata_q;
  logic              rsp_valid_q, rsp_err_q;
  logic [31:0]       rsp_rdata_q;
  logic              push, pop, tmo_hit;
  cmd_t              head;

  assign push    = cmd_valid_i && ready_q;
  assign pop     = (state_q == StIdle) && (cnt_q != '0);
  assign head    = fifo_q[rd_ptr_q];
  assign tmo_hit = TmoEn && (tmr_q == TmrLast);

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Storage needs no reset; validity is tracked by cnt_q.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= '{we: cmd_we_i, addr: cmd_addr_i, wdata: cmd_wdata_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q   <= cnt_d;
      ready_q <= (cnt_d != CntW'(CMD_DEPTH));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      tmr_q       <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      we_pend_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cnt_q != '0) begin
            req_q     <= 1'b1;
            we_q      <= head.we;
            we_pend_q <= head.we;
            addr_q    <= head.addr;
            wdata_q   <= head.wdata;
            tmr_q     <= '0;
            state_q   <= StReq;
          end
        end
        StReq: begin
          if (dbg_gnt_i) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            tmr_q   <= '0;
            state_q <= StWaitRv;
          end else if (tmo_hit) begin
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
            state_q     <= StResp;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        StWaitRv: begin
          // Entered the cycle after gnt, so an rvalid coincident with gnt is never seen here.
          if (dbg_rvalid_i) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= we_pend_q ? '0 : dbg_rdata_i;
            state_q     <= StResp;
          end else if (tmo_hit) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
            state_q     <= StResp;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        StResp: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready_o = ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_error_o = rsp_err_q;
  assign busy_o      = (cnt_q != '0) || (state_q != StIdle);
  assign dbg_req_o   = req_q;
  assign dbg_we_o    = we_q;
  assign dbg_addr_o  = addr_q;
  assign dbg_wdata_o = wdata_q;

endmodule

// File: tb/tb_riscv_pert_dbg_master.sv
// Bench for riscv_pert_dbg_master: behavioural debug slave, reference register model and
// an in-order response scoreboard.
module tb_riscv_pert_dbg_master;

  localparam int unsigned Depth = 4;
  localparam int unsigned To    = 8;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [14:0] cmd_addr_i;
  logic [31:0] cmd_wdata_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_error_o, busy_o;
  logic [31:0] rsp_rdata_o;
  logic        dbg_req_o, dbg_gnt_i, dbg_rvalid_i, dbg_we_o;
  logic [14:0] dbg_addr_o;
  logic [31:0] dbg_wdata_o, dbg_rdata_i;

  riscv_pert_dbg_master #(
    .CMD_DEPTH      (Depth),
    .TIMEOUT_CYCLES (To)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_we_i     (cmd_we_i),
    .cmd_addr_i   (cmd_addr_i),
    .cmd_wdata_i  (cmd_wdata_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_error_o  (rsp_error_o),
    .busy_o       (busy_o),
    .dbg_req_o    (dbg_req_o),
    .dbg_gnt_i    (dbg_gnt_i),
    .dbg_rvalid_i (dbg_rvalid_i),
    .dbg_we_o     (dbg_we_o),
    .dbg_addr_o   (dbg_addr_o),
    .dbg_wdata_o  (dbg_wdata_o),
    .dbg_rdata_i  (dbg_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int gnt_dly;   // req cycles before gnt
    int rv_dly;    // cycles after the gnt cycle until rvalid
    bit rv_drop;   // no rvalid after gnt
    bit rv_in_gnt; // rvalid pulsed in the gnt cycle
  } beh_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  beh_t        beh_q[$];
  exp_t        exp_q[$];
  logic [31:0] ref_mem [16];
  logic [31:0] slv_mem [16];
  int          n_chk = 0;
  int          n_fail = 0;
  int          ready_mode = 0;
  bit          in_rst = 1'b0;
  int          push_cyc, req_cyc;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endfunction

  function automatic void fail_now(string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event outcome wrong (got unexpected/none, required expected event)", name);
  endfunction

  function automatic beh_t mk(int g, int r, bit d, bit ig);
    beh_t b;
    b.gnt_dly = g; b.rv_dly = r; b.rv_drop = d; b.rv_in_gnt = ig;
    return b;
  endfunction

  // Reference: timeout rules applied directly to the chosen slave behaviour.
  task automatic push(input bit we, input logic [3:0] idx, input logic [31:0] wd, input beh_t b);
    exp_t e;
    bit   ok = 1'b0;
    cmd_valid_i = 1'b1;
    cmd_we_i    = we;
    cmd_addr_i  = 15'h0600 | {9'd0, idx, 2'b00};
    cmd_wdata_i = wd;
    for (int i = 0; i < 1000; i++) begin
      if (cmd_ready_o) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) fail_now("push_accept");
    push_cyc = cyc;
    if (b.gnt_dly >= int'(To)) begin
      e = '{rdata: 32'h0, err: 1'b1};
    end else begin
      if (we) ref_mem[idx] = wd;
      if (b.rv_drop || b.rv_dly > int'(To)) e = '{rdata: 32'h0, err: 1'b1};
      else e = '{rdata: (we ? 32'h0 : ref_mem[idx]), err: 1'b0};
    end
    beh_q.push_back(b);
    exp_q.push_back(e);
    @(negedge clk);
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0 && !busy_o) return;
      @(negedge clk);
    end
    fail_now("wait_idle");
  endtask

  // Debug slave
  initial begin
    beh_t        b;
    logic        sw;
    logic [14:0] sa;
    logic [31:0] sd;
    bit          stable, granted;
    int          k;
    dbg_gnt_i = 1'b0; dbg_rvalid_i = 1'b0; dbg_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (dbg_req_o && !in_rst) begin
        req_cyc = cyc;
        if (beh_q.size() == 0) begin
          fail_now("unexpected_req");
          b = mk(0, 1, 1'b0, 1'b0);
        end else begin
          b = beh_q.pop_front();
        end
        sw = dbg_we_o; sa = dbg_addr_o; sd = dbg_wdata_o;
        stable = 1'b1; granted = 1'b0; k = 0;
        while (1) begin
          if (!dbg_req_o) break;
          if (dbg_we_o !== sw || dbg_addr_o !== sa || dbg_wdata_o !== sd) stable = 1'b0;
          if (k == b.gnt_dly) begin
            dbg_gnt_i = 1'b1;
            dbg_rvalid_i = b.rv_in_gnt;
            dbg_rdata_i = 32'hDEAD_BEEF;
            granted = 1'b1;
            @(negedge clk);
            dbg_gnt_i = 1'b0; dbg_rvalid_i = 1'b0; dbg_rdata_i = '0;
            break;
          end
          k++;
          @(negedge clk);
        end
        check("req_stable", 32'(stable), 32'd1);
        if (granted) begin
          check("req_low_after_gnt", 32'(dbg_req_o), 32'd0);
          check("addr_low_after_gnt", 32'(dbg_addr_o), 32'd0);
          if (sw) slv_mem[sa[5:2]] = sd;
          if (!b.rv_drop) begin
            for (int j = 1; j < b.rv_dly; j++) @(negedge clk);
            dbg_rvalid_i = 1'b1;
            dbg_rdata_i  = sw ? $urandom : slv_mem[sa[5:2]];
            @(negedge clk);
            dbg_rvalid_i = 1'b0; dbg_rdata_i = '0;
          end
        end else if (!in_rst) begin
          check("req_cycles_to_timeout", 32'(k), 32'(To));
        end
      end
    end
  end

  // Response monitor / scoreboard
  initial begin
    exp_t e;
    rsp_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       rsp_ready_i = ($urandom_range(3) != 0);
        1:       rsp_ready_i = 1'b1;
        default: rsp_ready_i = 1'b0;
      endcase
      if (rsp_valid_o && rsp_ready_i) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_rsp");
        end else begin
          e = exp_q.pop_front();
          check("rsp_rdata", rsp_rdata_o, e.rdata);
          check("rsp_error", 32'(rsp_error_o), 32'(e.err));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (got hang, required completion)");
    $fatal(1);
  end

  initial begin
    beh_t rb;
    cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_addr_i = '0; cmd_wdata_i = '0;
    for (int i = 0; i < 16; i++) begin ref_mem[i] = '0; slv_mem[i] = '0; end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_dbg_req", 32'(dbg_req_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write reg1, immediate gnt, then read back
    push(1'b1, 4'd1, 32'h10, mk(0, 1, 1'b0, 1'b0));
    wait_idle();
    check("req_latency", 32'(req_cyc - push_cyc), 32'd2);
    push(1'b0, 4'd1, 32'h0, mk(0, 1, 1'b0, 1'b0));
    wait_idle();

    // Read reg0 after writing 3, gnt delayed 5 cycles
    push(1'b1, 4'd0, 32'h3, mk(0, 1, 1'b0, 1'b0));
    push(1'b0, 4'd0, 32'h0, mk(5, 1, 1'b0, 1'b0));
    wait_idle();

    // Fill FIFO while the response is held off
    ready_mode = 2;
    for (int i = 0; i < 5; i++) push(1'b1, 4'(8 + i), $urandom, mk(0, 1, 1'b0, 1'b0));
    check("fifo_full_ready", 32'(cmd_ready_o), 32'd0);
    ready_mode = 0;
    wait_idle();

    // Timeouts and expiry-cycle boundaries
    push(1'b0, 4'd2, 32'h0, mk(100, 1, 1'b0, 1'b0));
    push(1'b1, 4'd3, $urandom, mk(0, 1, 1'b1, 1'b0));
    push(1'b0, 4'd3, 32'h0, mk(1, 2, 1'b0, 1'b0));
    push(1'b0, 4'd1, 32'h0, mk(To - 1, To, 1'b0, 1'b0));
    push(1'b0, 4'd1, 32'h0, mk(0, To + 1, 1'b0, 1'b0));
    wait_idle();

    // rvalid only in the gnt cycle
    push(1'b0, 4'd1, 32'h0, mk(2, 1, 1'b1, 1'b1));
    wait_idle();

    // Reset while in REQ
    push(1'b0, 4'd1, 32'h0, mk(100, 1, 1'b0, 1'b0));
    for (int i = 0; i < 20; i++) begin
      if (dbg_req_o) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    in_rst = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_req", 32'(dbg_req_o), 32'd0);
    check("async_rst_busy", 32'(busy_o), 32'd0);
    check("async_rst_ready", 32'(cmd_ready_o), 32'd1);
    exp_q.delete();
    beh_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("post_rst_ready", 32'(cmd_ready_o), 32'd1);
    in_rst = 1'b0;
    push(1'b1, 4'd5, 32'hCAFE_0005, mk(1, 2, 1'b0, 1'b0));
    push(1'b0, 4'd5, 32'h0, mk(0, 1, 1'b0, 1'b0));
    wait_idle();

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      rb.gnt_dly   = ($urandom_range(4) == 0) ? int'($urandom_range(To + 2)) : int'($urandom_range(2));
      rb.rv_dly    = ($urandom_range(4) == 0) ? int'($urandom_range(To + 1, 1))
                                              : int'($urandom_range(2, 1));
      rb.rv_drop   = ($urandom_range(19) == 0);
      rb.rv_in_gnt = rb.rv_drop && ($urandom_range(1) == 1);
      push($urandom_range(1) == 1, 4'($urandom_range(15)), $urandom, rb);
      repeat ($urandom_range(3)) @(negedge clk);
    end
    wait_idle();
    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
